// File: rtl/ip_sdram_arbiter.sv
// Two-port SDRAM command arbiter (refresh > VDP > host) with a periodic refresh timer.
// Optional host anti-starvation is enabled by defining SDRAM_ARB_FAIRNESS_EN.
`timescale 1ns/1ps
module ip_sdram_arbiter #(
  parameter int REFRESH_INTERVAL  = 670,
  parameter int HOST_STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vdp_req,
  input  logic        vdp_wr,
  input  logic [22:0] vdp_address,
  input  logic [7:0]  vdp_wdata,
  output logic        vdp_ack,
  output logic [15:0] vdp_rdata,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [22:0] host_address,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        mem_req,
  output logic        mem_refresh,
  output logic        mem_wr,
  output logic [22:0] mem_address,
  output logic [7:0]  mem_wdata,
  input  logic        mem_busy,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        refresh_overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, REFRESH} state_t;

  localparam logic [9:0] RELOAD = 10'(REFRESH_INTERVAL - 1);

  if (REFRESH_INTERVAL < 2 || REFRESH_INTERVAL > 1024) begin : g_bad_interval
    $error("REFRESH_INTERVAL must fit the 10-bit refresh counter");
  end
  if (HOST_STARVE_LIMIT < 1 || HOST_STARVE_LIMIT > 7) begin : g_bad_starve
    $error("HOST_STARVE_LIMIT must fit the 3-bit starve counter");
  end

  state_t     state, state_next;
  logic       grant_vdp, grant_host, start_refresh;
  logic       host_first, owner_host, txn_done;
  logic       refresh_pending, refresh_expire;
  logic [9:0] refresh_cnt;

`ifdef SDRAM_ARB_FAIRNESS_EN
  localparam logic [2:0] STARVE_LIMIT = 3'(HOST_STARVE_LIMIT);
  logic [2:0] starve_cnt;

  assign host_first = (starve_cnt >= STARVE_LIMIT);

  // Counts VDP wins only while the host is actually waiting; saturates at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (grant_host)
      starve_cnt <= '0;
    else if (grant_vdp && host_req && starve_cnt < STARVE_LIMIT)
      starve_cnt <= starve_cnt + 3'd1;
  end
`else
  assign host_first = 1'b0;
`endif

  assign txn_done = (state == WAIT_DONE) && mem_done;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next    = state;
    grant_vdp     = 1'b0;
    grant_host    = 1'b0;
    start_refresh = 1'b0;
    unique case (state)
      IDLE: begin
        if (!mem_busy) begin
          if (refresh_pending) begin
            start_refresh = 1'b1;
            state_next    = REFRESH;
          // Requesters still hold req during their ack cycle; sampling then would double-grant.
          end else if (!(vdp_ack || host_ack)) begin
            if (host_req && (host_first || !vdp_req)) begin
              grant_host = 1'b1;
              state_next = ISSUE;
            end else if (vdp_req) begin
              grant_vdp  = 1'b1;
              state_next = ISSUE;
            end
          end
        end
      end
      ISSUE:              state_next = WAIT_DONE;
      WAIT_DONE, REFRESH: if (mem_done) state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_refresh <= 1'b0;
      mem_wr      <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      owner_host  <= 1'b0;
      vdp_ack     <= 1'b0;
      host_ack    <= 1'b0;
      vdp_rdata   <= '0;
      host_rdata  <= '0;
    end else begin
      state       <= state_next;
      mem_req     <= grant_vdp || grant_host;
      mem_refresh <= start_refresh;
      if (grant_host) begin
        mem_address <= host_address;
        mem_wdata   <= host_wdata;
        mem_wr      <= host_wr;
        owner_host  <= 1'b1;
      end else if (grant_vdp) begin
        mem_address <= vdp_address;
        mem_wdata   <= vdp_wdata;
        mem_wr      <= vdp_wr;
        owner_host  <= 1'b0;
      end
      vdp_ack  <= txn_done && !owner_host;
      host_ack <= txn_done && owner_host;
      if (txn_done && !mem_wr) begin
        if (owner_host) host_rdata <= mem_rdata;
        else            vdp_rdata  <= mem_rdata;
      end
    end
  end

  assign refresh_expire = (refresh_cnt == 10'd0);

  // Pending is a single flag: an expiry that finds it already set is recorded as an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt     <= RELOAD;
      refresh_pending <= 1'b0;
      refresh_overrun <= 1'b0;
    end else begin
      refresh_cnt <= refresh_expire ? RELOAD : refresh_cnt - 10'd1;
      if (refresh_expire)
        refresh_pending <= 1'b1;
      else if (start_refresh)
        refresh_pending <= 1'b0;
      if (refresh_expire && refresh_pending)
        refresh_overrun <= 1'b1;
    end
  end

endmodule

// File: doc/ip_sdram_arbiter.md
IP_SDRAM_ARBITER -- requirements
Module: ip_sdram_arbiter

Interface
REQ-001 The block SHALL have these parameters: REFRESH_INTERVAL, 670, clk cycles between refresh requests (7.8 us at 85.9 MHz); HOST_STARVE_LIMIT, 4, consecutive VDP grants tolerated while host waits.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-high.
REQ-004 vdp_req / vdp_wr  input  1 / 1  VDP access request, held until vdp_ack; write when 1.
REQ-005 vdp_address / vdp_wdata  input  23 / 8  VDP word address and write byte.
REQ-006 vdp_ack / vdp_rdata  output  1 / 16  one-cycle completion pulse; read data valid while vdp_ack=1.
REQ-007 host_req / host_wr  input  1 / 1  host access request, held until host_ack; write when 1.
REQ-008 host_address / host_wdata  input  23 / 8  host word address and write byte.
REQ-009 host_ack / host_rdata  output  1 / 16  one-cycle completion pulse; read data valid while host_ack=1.
REQ-010 mem_req / mem_refresh / mem_wr  output  1 / 1 / 1  one-cycle command pulses to the SDRAM controller; mem_wr qualifies mem_req.
REQ-011 mem_address / mem_wdata  output  23 / 8  command address and write data, stable from mem_req until mem_done.
REQ-012 mem_busy / mem_done  input  1 / 1  controller busy (initialisation or operation); one-cycle completion of any command.
REQ-013 mem_rdata  input  16  read data, valid while mem_done=1 after a read.
REQ-014 refresh_overrun  output  1  sticky: a refresh interval expired while the previous refresh was still pending.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT_DONE, REFRESH; no other states reachable.
REQ-016 IDLE with mem_busy=1 SHALL stay IDLE and issue nothing.
REQ-017 IDLE with mem_busy=0 SHALL choose, in priority order, pending refresh -> REFRESH, else VDP -> ISSUE, else host -> ISSUE, else stay IDLE.
REQ-018 On entering ISSUE the block SHALL latch the winner's address, wdata and wr into mem_address/mem_wdata/mem_wr and assert mem_req for exactly one cycle, then go to WAIT_DONE.
REQ-019 WAIT_DONE SHALL wait for mem_done; in that cycle capture mem_rdata (reads only; writes leave rdata unchanged), pulse the winner's ack in the next cycle, and return to IDLE.
REQ-020 REFRESH SHALL pulse mem_refresh for one cycle, clear the refresh pending flag, wait for mem_done, and return to IDLE.
REQ-021 Grant-to-mem_req latency SHALL be 1 cycle; mem_done-to-ack latency SHALL be 1 cycle.
REQ-022 Requests SHALL NOT be sampled in the cycle an ack is high; a requester dropping req the cycle after ack is never granted twice.
REQ-023 A 10-bit down-counter SHALL reload REFRESH_INTERVAL-1 and set the pending flag when it reaches 0, counting in every state.
REQ-024 Counter expiry with pending already set SHALL set refresh_overrun; pending stays single, not queued.
REQ-025 mem_done in IDLE SHALL be ignored.
REQ-026 vdp_ack and host_ack SHALL never be high in the same cycle.

Reset
REQ-027 reset=1 SHALL force, immediately and regardless of clk, state IDLE, counter REFRESH_INTERVAL-1, pending 0, starve counter 0, and all outputs 0 (including rdata buses and refresh_overrun).
REQ-028 Reset asserted mid-transaction SHALL abort it with no ack; the first grant after release follows REQ-017.

Configuration
REQ-029 With SDRAM_ARB_FAIRNESS_EN defined, a 3-bit starve counter SHALL increment on each VDP grant while host_req=1 and clear on a host grant; at HOST_STARVE_LIMIT the next non-refresh arbitration with both requesting SHALL go to host.
REQ-030 Without SDRAM_ARB_FAIRNESS_EN, VDP SHALL always beat host and no starve counter SHALL exist.

Verification
REQ-031 VDP read 0x000123, mem_done after 5 cycles with mem_rdata=0xBEEF -> one mem_req with mem_wr=0, then vdp_ack 1 cycle after mem_done, vdp_rdata=0xBEEF.
REQ-032 vdp_req and host_req raised in the same cycle -> VDP served first; host_ack only after vdp_ack and a fresh mem_req.
REQ-033 REFRESH_INTERVAL=16, no requests, mem_done 2 cycles after each command -> mem_refresh every 16 cycles, refresh_overrun stays 0.
REQ-034 REFRESH_INTERVAL=16, mem_busy held 40 cycles -> no commands issued, refresh_overrun=1, exactly one mem_refresh after mem_busy falls.
REQ-035 SDRAM_ARB_FAIRNESS_EN defined, VDP and host requesting continuously -> host granted after every 4 VDP grants; macro undefined -> host never granted.
REQ-036 reset pulsed in WAIT_DONE -> all outputs 0 at once, no ack; a later vdp_req is served normally.
